// File: rtl/char_writer_if.sv
// Byte-stream handshake between the receive path (master) and char_writer (slave).
interface char_writer_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/char_writer.sv
// VT52-style write controller for the 16x64 character buffer: cursor, scroll offset and bulk erase.
// Optional ESC Y direct cursor addressing is built when DIRECT_CURSOR_ADDR_EN is defined.
module char_writer #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 6
) (
   input  logic                         clk,
   input  logic                         reset,
   char_writer_if.slave                 in_if,
   output logic [7:0]                   new_char,
   output logic [ROW_BITS+COL_BITS-1:0] new_char_address,
   output logic                         new_char_wen,
   output logic [COL_BITS-1:0]          cursor_x,
   output logic [ROW_BITS-1:0]          cursor_y,
   output logic [ROW_BITS-1:0]          first_row
);

   localparam logic [7:0] C_BS  = 8'h08;
   localparam logic [7:0] C_TAB = 8'h09;
   localparam logic [7:0] C_LF  = 8'h0A;
   localparam logic [7:0] C_CR  = 8'h0D;
   localparam logic [7:0] C_ESC = 8'h1B;
   localparam logic [7:0] C_SP  = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ESC,
      S_CLEAR
`ifdef DIRECT_CURSOR_ADDR_EN
      , S_Y_ROW
      , S_Y_COL
`endif
   } state_t;

   state_t                        r_state;
   logic                          r_ready;
   logic [COL_BITS-1:0]           r_cursor_x;
   logic [ROW_BITS-1:0]           r_cursor_y;
   logic [ROW_BITS-1:0]           r_first_row;
   logic [7:0]                    r_new_char;
   logic [ROW_BITS+COL_BITS-1:0]  r_new_char_address;
   logic                          r_new_char_wen;
   // Erase position is the screen-relative cell most recently written.
   logic [ROW_BITS-1:0]           r_clr_row;
   logic [COL_BITS-1:0]           r_clr_col;
   logic [ROW_BITS-1:0]           r_clr_last_row;

   logic [7:0]                    w_byte;
   logic                          w_printable;
   logic [COL_BITS:0]             w_tab_sum;
   logic [COL_BITS-1:0]           w_tab_x;
   logic [ROW_BITS-1:0]           w_cur_phys;
   logic [ROW_BITS-1:0]           w_first_row_inc;
   logic [COL_BITS-1:0]           w_clr_next_col;
   logic [ROW_BITS-1:0]           w_clr_next_row;
   logic [ROW_BITS-1:0]           w_clr_next_phys;
   logic                          w_clr_done;

   assign w_byte          = in_if.data;
   assign w_printable     = (w_byte >= 8'h20) && (w_byte <= 8'h7E);
   assign w_tab_sum       = ({1'b0, r_cursor_x} | (COL_BITS+1)'(7)) + (COL_BITS+1)'(1);
   assign w_tab_x         = w_tab_sum[COL_BITS] ? '1 : w_tab_sum[COL_BITS-1:0];
   assign w_cur_phys      = r_first_row + r_cursor_y;
   assign w_first_row_inc = r_first_row + ROW_BITS'(1);
   assign w_clr_next_col  = r_clr_col + COL_BITS'(1);
   assign w_clr_next_row  = (&r_clr_col) ? r_clr_row + ROW_BITS'(1) : r_clr_row;
   assign w_clr_next_phys = r_first_row + w_clr_next_row;
   assign w_clr_done      = (r_clr_row == r_clr_last_row) && (&r_clr_col);

`ifdef DIRECT_CURSOR_ADDR_EN
   logic [7:0] w_y_off;
   logic       w_y_row_ok;
   logic       w_y_col_ok;

   assign w_y_off    = w_byte - C_SP;
   assign w_y_row_ok = (w_byte >= C_SP) && (w_y_off < 8'(1 << ROW_BITS));
   assign w_y_col_ok = (w_byte >= C_SP) && (w_y_off < 8'(1 << COL_BITS));
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state            <= S_IDLE;
         r_ready            <= 1'b1;
         r_cursor_x         <= '0;
         r_cursor_y         <= '0;
         r_first_row        <= '0;
         r_new_char         <= 8'h00;
         r_new_char_address <= '0;
         r_new_char_wen     <= 1'b0;
         r_clr_row          <= '0;
         r_clr_col          <= '0;
         r_clr_last_row     <= '0;
      end else begin
         // NOTE: the strobe defaults low every cycle; only the branches that write raise it.
         r_new_char_wen <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (in_if.valid) begin
                  if (w_printable) begin
                     r_new_char         <= w_byte;
                     r_new_char_address <= {w_cur_phys, r_cursor_x};
                     r_new_char_wen     <= 1'b1;
                     if (r_cursor_x != '1) r_cursor_x <= r_cursor_x + COL_BITS'(1);
                  end else begin
                     case (w_byte)
                        C_CR:  r_cursor_x <= '0;
                        C_BS:  if (r_cursor_x != '0) r_cursor_x <= r_cursor_x - COL_BITS'(1);
                        C_TAB: r_cursor_x <= w_tab_x;
                        C_ESC: r_state    <= S_ESC;
                        C_LF: begin
                           if (r_cursor_y != '1) begin
                              r_cursor_y <= r_cursor_y + ROW_BITS'(1);
                           end else begin
                              // Old top row becomes the new bottom row and is blanked.
                              r_first_row        <= w_first_row_inc;
                              r_new_char         <= C_SP;
                              r_new_char_address <= {r_first_row, {COL_BITS{1'b0}}};
                              r_new_char_wen     <= 1'b1;
                              r_clr_row          <= '1;
                              r_clr_col          <= '0;
                              r_clr_last_row     <= '1;
                              r_ready            <= 1'b0;
                              r_state            <= S_CLEAR;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end

            S_ESC: begin
               if (in_if.valid) begin
                  r_state <= S_IDLE;
                  case (w_byte)
                     "A": if (r_cursor_y != '0) r_cursor_y <= r_cursor_y - ROW_BITS'(1);
                     "B": if (r_cursor_y != '1) r_cursor_y <= r_cursor_y + ROW_BITS'(1);
                     "C": if (r_cursor_x != '1) r_cursor_x <= r_cursor_x + COL_BITS'(1);
                     "D": if (r_cursor_x != '0) r_cursor_x <= r_cursor_x - COL_BITS'(1);
                     "H": begin
                        r_cursor_x <= '0;
                        r_cursor_y <= '0;
                     end
                     "J", "K": begin
                        r_new_char         <= C_SP;
                        r_new_char_address <= {w_cur_phys, r_cursor_x};
                        r_new_char_wen     <= 1'b1;
                        r_clr_row          <= r_cursor_y;
                        r_clr_col          <= r_cursor_x;
                        r_clr_last_row     <= (w_byte == "J") ? '1 : r_cursor_y;
                        r_ready            <= 1'b0;
                        r_state            <= S_CLEAR;
                     end
`ifdef DIRECT_CURSOR_ADDR_EN
                     "Y": r_state <= S_Y_ROW;
`endif
                     default: ;
                  endcase
               end
            end

`ifdef DIRECT_CURSOR_ADDR_EN
            S_Y_ROW: begin
               if (in_if.valid) begin
                  if (w_y_row_ok) r_cursor_y <= w_y_off[ROW_BITS-1:0];
                  r_state <= S_Y_COL;
               end
            end

            S_Y_COL: begin
               if (in_if.valid) begin
                  if (w_y_col_ok) r_cursor_x <= w_y_off[COL_BITS-1:0];
                  r_state <= S_IDLE;
               end
            end
`endif

            S_CLEAR: begin
               if (w_clr_done) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_new_char_address <= {w_clr_next_phys, w_clr_next_col};
                  r_new_char_wen     <= 1'b1;
                  r_clr_row          <= w_clr_next_row;
                  r_clr_col          <= w_clr_next_col;
               end
            end

            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_if.ready      = r_ready;
   assign new_char         = r_new_char;
   assign new_char_address = r_new_char_address;
   assign new_char_wen     = r_new_char_wen;
   assign cursor_x         = r_cursor_x;
   assign cursor_y         = r_cursor_y;
   assign first_row        = r_first_row;

endmodule

// File: tb/tb_char_writer.sv
// Scoreboard bench for char_writer: directed byte stream, expected writes queued, monitor compares.
module tb_char_writer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] new_char;
   logic [9:0] new_char_address;
   logic       new_char_wen;
   logic [5:0] cursor_x;
   logic [3:0] cursor_y;
   logic [3:0] first_row;

   char_writer_if u_if ();

   char_writer #(.ROW_BITS(4), .COL_BITS(6)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_if            (u_if),
      .new_char         (new_char),
      .new_char_address (new_char_address),
      .new_char_wen     (new_char_wen),
      .cursor_x         (cursor_x),
      .cursor_y         (cursor_y),
      .first_row        (first_row)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] ch;
      logic [9:0] addr;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_tests     = 0;
   int  n_fail      = 0;
   int  n_writes    = 0;
   int  n_ready_low = 0;
   bit  bypass      = 1'b0;
   int  w0;
   int  r0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_wr(input logic [7:0] ch, input logic [9:0] addr);
      exp_q.push_back('{ch: ch, addr: addr});
   endtask

   // Monitor: every write strobe pops one expected write.
   always @(negedge clk) begin
      if (!reset) begin
         if (!u_if.ready) n_ready_low++;
         if (new_char_wen) begin
            n_writes++;
            if (!bypass) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_write: got 0x%02h at 0x%03h, none expected", new_char, new_char_address);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("wr_data", {24'd0, new_char}, {24'd0, mon_e.ch});
                  check("wr_addr", {22'd0, new_char_address}, {22'd0, mon_e.addr});
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int waited = 0;
      u_if.data  = b;
      u_if.valid = 1'b1;
      while (!u_if.ready) begin
         @(negedge clk);
         waited++;
         if (waited > 3000) begin
            $display("FAIL send_timeout: ready stuck low, got 0 expected 1, byte 0x%02h", b);
            $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
            $fatal(1, "ready timeout");
         end
      end
      @(posedge clk);
      #1;
      u_if.valid = 1'b0;
   endtask

   task automatic esc(input logic [7:0] c);
      send(8'h1B);
      send(c);
   endtask

   task automatic wait_ready(input string name);
      int waited = 0;
      while (!u_if.ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check(name, {31'd0, u_if.ready}, 32'd1);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      u_if.data  = 8'h00;
      u_if.valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready",    {31'd0, u_if.ready},       32'd1);
      check("rst_cursor_x", {26'd0, cursor_x},         32'd0);
      check("rst_cursor_y", {28'd0, cursor_y},         32'd0);
      check("rst_first",    {28'd0, first_row},        32'd0);
      check("rst_wen",      {31'd0, new_char_wen},     32'd0);
      check("rst_char",     {24'd0, new_char},         32'd0);
      check("rst_addr",     {22'd0, new_char_address}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two printable characters
      w0 = n_writes;
      exp_wr(8'h41, 10'h000); send(8'h41);
      exp_wr(8'h42, 10'h001); send(8'h42);
      check("ab_cursor_x", {26'd0, cursor_x}, 32'd2);
      settle();
      check("ab_write_count", n_writes - w0, 32'd2);

      // 70 characters from column 0: no autowrap, last ones overwrite column 63
      send(8'h0D);
      w0 = n_writes;
      for (int i = 0; i < 70; i++) begin
         exp_wr(8'h78, (i < 63) ? 10'(i) : 10'h03F);
         send(8'h78);
      end
      check("x70_cursor_x", {26'd0, cursor_x}, 32'd63);
      settle();
      check("x70_write_count", n_writes - w0, 32'd70);

      // Move to (60,2) via ESC B, CR, TAB and ESC C
      esc("B"); esc("B"); send(8'h0D);
      check("escb_cursor_y", {28'd0, cursor_y}, 32'd2);
      send(8'h09);
      check("tab_8", {26'd0, cursor_x}, 32'd8);
      for (int i = 0; i < 6; i++) send(8'h09);
      check("tab_56", {26'd0, cursor_x}, 32'd56);
      for (int i = 0; i < 4; i++) esc("C");
      check("escc_60", {26'd0, cursor_x}, 32'd60);

      // ESC K at (60,2): four blanks 0x0BC..0x0BF
      for (int i = 0; i < 4; i++) exp_wr(8'h20, 10'h0BC + 10'(i));
      r0 = n_ready_low;
      esc("K");
      wait_ready("escK_ready_back");
      check("escK_ready_low", n_ready_low - r0, 32'd4);
      check("escK_cursor_x", {26'd0, cursor_x}, 32'd60);
      check("escK_cursor_y", {28'd0, cursor_y}, 32'd2);

      // Saturation of TAB, BS, cursor keys and home
      send(8'h09);
      check("tab_sat", {26'd0, cursor_x}, 32'd63);
      send(8'h08);
      check("bs_62", {26'd0, cursor_x}, 32'd62);
      esc("D");
      check("escd_61", {26'd0, cursor_x}, 32'd61);
      esc("H");
      check("home_x", {26'd0, cursor_x}, 32'd0);
      check("home_y", {28'd0, cursor_y}, 32'd0);
      send(8'h08);
      check("bs_sat", {26'd0, cursor_x}, 32'd0);
      esc("A");
      check("esca_sat", {28'd0, cursor_y}, 32'd0);
      for (int i = 0; i < 16; i++) esc("B");
      check("escb_sat", {28'd0, cursor_y}, 32'd15);
      check("escb_no_scroll", {28'd0, first_row}, 32'd0);

      // LF on the bottom row scrolls and blanks physical row 0
      for (int i = 0; i < 64; i++) exp_wr(8'h20, 10'(i));
      r0 = n_ready_low;
      send(8'h0A);
      check("scroll_first_row", {28'd0, first_row}, 32'd1);
      check("scroll_first_wen", {31'd0, new_char_wen}, 32'd1);
      check("scroll_ready_low", {31'd0, u_if.ready}, 32'd0);
      wait_ready("scroll_ready_back");
      check("scroll_ready_cycles", n_ready_low - r0, 32'd64);
      check("scroll_cursor_y", {28'd0, cursor_y}, 32'd15);

      // Bottom row now maps to physical row 0; ignored bytes and unknown escape
      exp_wr(8'h5A, 10'h000); send(8'h5A);
      send(8'h01); send(8'h7F);
      check("ignored_x", {26'd0, cursor_x}, 32'd1);
      esc("Q");
      exp_wr(8'h71, 10'h001); send(8'h71);
      check("unknown_esc_x", {26'd0, cursor_x}, 32'd2);

`ifdef DIRECT_CURSOR_ADDR_EN
      esc("Y"); send(8'h25); send(8'h30);
      check("escy_y", {28'd0, cursor_y}, 32'd5);
      check("escy_x", {26'd0, cursor_x}, 32'd16);
      esc("Y"); send(8'h40); send(8'h30);
      check("escy_badrow_y", {28'd0, cursor_y}, 32'd5);
      check("escy_badrow_x", {26'd0, cursor_x}, 32'd16);
`else
      esc("Y");
      exp_wr(8'h25, 10'h002); send(8'h25);
      exp_wr(8'h30, 10'h003); send(8'h30);
      check("noy_x", {26'd0, cursor_x}, 32'd4);
      check("noy_y", {28'd0, cursor_y}, 32'd15);
`endif

      // ESC J at (60,15) with first_row 1: four blanks on physical row 0
      esc("H");
      for (int i = 0; i < 15; i++) esc("B");
      send(8'h0D);
      for (int i = 0; i < 7; i++) send(8'h09);
      for (int i = 0; i < 4; i++) esc("C");
      check("escJ_pos_x", {26'd0, cursor_x}, 32'd60);
      for (int i = 0; i < 4; i++) exp_wr(8'h20, 10'h03C + 10'(i));
      r0 = n_ready_low;
      esc("J");
      wait_ready("escJ_ready_back");
      check("escJ_ready_low", n_ready_low - r0, 32'd4);

      // Full-screen ESC J aborted by reset
      esc("H");
      settle();
      bypass = 1'b1;
      esc("J");
      check("abort_first_wen",  {31'd0, new_char_wen},     32'd1);
      check("abort_first_addr", {22'd0, new_char_address}, 32'h040);
      check("abort_ready_low",  {31'd0, u_if.ready},       32'd0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_wen",   {31'd0, new_char_wen}, 32'd0);
      check("abort_first", {28'd0, first_row},    32'd0);
      check("abort_x",     {26'd0, cursor_x},     32'd0);
      check("abort_y",     {28'd0, cursor_y},     32'd0);
      check("abort_char",  {24'd0, new_char},     32'd0);
      @(negedge clk);
      reset  = 1'b0;
      bypass = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready_after", {31'd0, u_if.ready}, 32'd1);
      exp_wr(8'h45, 10'h000); send(8'h45);
      check("post_reset_x", {26'd0, cursor_x}, 32'd1);
      settle();
      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/char_writer.md
# char_writer

Upstream write controller for the 1k×8 character buffer (16 rows × 64 columns). Consumes a byte stream from the receive path and interprets printable characters, control codes and VT52 escape sequences. Produces single-cycle character writes into the buffer, tracks the cursor and maintains the hardware scroll offset (`first_row`) used by the video path. Bulk erases (scroll, ESC J, ESC K) are sequenced internally, with backpressure on the input.

## Interface
Parameters:
- `ROW_BITS`, 4: row index width; 16 rows.
- `COL_BITS`, 6: column index width; 64 columns. Buffer address width is `ROW_BITS+COL_BITS` = 10.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  8  incoming byte.
- `valid`  in  1  `data` is valid.
- `ready`  out  1  byte accepted on a cycle with `valid && ready`.
- `new_char`  out  8  write data to the char buffer.
- `new_char_address`  out  10  write address: {physical row, column}.
- `new_char_wen`  out  1  write strobe, one cycle per character.
- `cursor_x`  out  6  cursor column, screen-relative.
- `cursor_y`  out  4  cursor row, screen-relative.
- `first_row`  out  4  physical buffer row shown at the top of the screen.

## Operation
- All outputs are registered.
- Physical row is `(first_row + screen_row) mod 16`.
- States:
  - IDLE, ESC, ESC_Y_ROW, ESC_Y_COL: `ready`=1.
  - CLEAR: `ready`=0.
- IDLE, on each accepted byte:
  - 0x20–0x7E: write the byte at the cursor, then `cursor_x`++, saturating at 63. No autowrap: further characters overwrite column 63.
  - 0x0D CR: `cursor_x`=0.
  - 0x08 BS: `cursor_x`--, saturating at 0.
  - 0x09 TAB: `cursor_x` moves to the next multiple of 8, saturating at 63.
  - 0x0A LF: if `cursor_y`<15, `cursor_y`++. If `cursor_y`=15, scroll:
    - `first_row`++ (mod 16).
    - Enter CLEAR for 64 cells of physical row old `first_row`, which is the new bottom row.
  - 0x1B: go to ESC.
  - All other bytes: ignored.
- ESC, on the next accepted byte:
  - 'A': up, saturating. 'B': down, saturating, never scrolls. 'C': right, saturating. 'D': left, saturating.
  - 'H': home (0,0).
  - 'J': CLEAR from cursor to end of screen, (64·(15−y)+(64−x)) cells, in screen order.
  - 'K': CLEAR from cursor to column 63 of the current row, (64−x) cells.
  - 'Y': go to ESC_Y_ROW (see Configuration).
  - Any other byte: return to IDLE, no effect.
- ESC_Y_ROW: row = byte−0x20, applied only if the result is 0..15; otherwise the row is unchanged. Go to ESC_Y_COL.
- ESC_Y_COL: col = byte−0x20, applied only if the result is 0..63; otherwise unchanged. Return to IDLE.
- CLEAR:
  - Writes 0x20 once per cycle, with the address stepping through screen order and wrapping physical rows mod 16.
  - The cursor does not move.
  - Returns to IDLE after the last write.
- Reset, asynchronous, including mid-CLEAR: the erase is aborted and all registers are forced:
  - state IDLE, `ready`=1
  - `cursor_x`=0, `cursor_y`=0, `first_row`=0
  - `new_char_wen`=0, `new_char`=0x00, `new_char_address`=0

## Timing
- Printable byte accepted at edge N: `new_char`/`new_char_address`/`new_char_wen`=1 are valid during cycle N+1. The cursor update is visible at N+1.
- Back-to-back printable bytes sustain one write per cycle.
- CLEAR of K cells: `ready` low from cycle N+1 through N+K; `new_char_wen` high for cycles N+1..N+K; `ready` high again at N+K+1.
- Scroll: `first_row` and the first clear write both change at edge N+1.
- No input byte is accepted while `ready`=0; the upstream block holds `data`/`valid`.
- `new_char_wen` is never high for more than one cycle per printable byte. It is low in all cycles without a write.

## Configuration
- `DIRECT_CURSOR_ADDR_EN` defined:
  - ESC Y row col is supported as described.
- Not defined:
  - ESC_Y_ROW and ESC_Y_COL are not built.
  - 'Y' after ESC is treated as an unknown code: return to IDLE, no effect.
  - The following row/col bytes are processed as ordinary IDLE input.

## Test plan
- Reset, then send 'A','B' → writes 0x41@0x000, 0x42@0x001; `cursor_x`=2; `new_char_wen` high exactly 2 cycles.
- Send 70 × 'x' from column 0 → 70 writes. Last 7 writes go to address 0x03F; `cursor_x`=63.
- With cursor at row 15, send LF:
  - `first_row`=1.
  - 64 writes of 0x20 at 0x000..0x03F.
  - `ready` low exactly 64 cycles.
  - `cursor_y` stays 15.
- Cursor (x=60, y=2) with `first_row`=0, send ESC K → 4 writes of 0x20 at 0x0BC..0x0BF; then ESC H → cursor (0,0).
- ESC Y 0x25 0x30 → cursor (y=5, x=16). ESC Y 0x40 0x30 → row unchanged, x=16. Without the macro: ESC Y 0x25 writes 0x25 at the cursor.
- Assert `reset` during an ESC J clear → `new_char_wen` drops immediately; cursor (0,0); `first_row`=0; `ready`=1 after release.
